// File: rtl/atari7800_pkg.sv
// Shared Atari 7800 MARIA definitions: DLL fetch states and DLL entry byte0 layout.
package atari7800_pkg;

    // Display-list-list fetch sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StF0,
        StF1,
        StF2,
        StReady
    } dll_state_e;

    // DLL entry byte0 bit positions.
    localparam int unsigned DllDliBit    = 7;
    localparam int unsigned DllH16Bit    = 6;
    localparam int unsigned DllH8Bit     = 5;
    localparam int unsigned DllRsvdBit   = 4;
    localparam int unsigned DllOffsetMsb = 3;

    // Each DLL entry is byte0 (flags/offset), byte1 (DL high), byte2 (DL low).
    localparam int unsigned DLL_ENTRY_BYTES = 3;

    // Address of byte idx of the DLL entry at base; wraps modulo 2^16.
    function automatic logic [15:0] dll_byte_addr(input logic [15:0] base, input logic [1:0] idx);
        return base + {14'd0, idx};
    endfunction

endpackage

// File: rtl/dll_fetcher.sv
// DLL fetcher: walks the display-list list one 3-byte entry per zone, presents the active
// display-list pointer, line offset and holey flags, and raises DLI at zone ends.
module dll_fetcher
    import atari7800_pkg::*;
(
    input  logic        sysclock,
    input  logic        reset_b,
    input  logic [15:0] ZP,
    input  logic        zp_written,
    input  logic        frame_start,
    input  logic        line_start,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [15:0] dl_ptr,
    output logic [3:0]  offset,
    output logic [1:0]  holey,
    output logic        dl_valid,
    output logic        dli,
    output logic        overrun
);

    dll_state_e  state;
    logic [15:0] ptr;         // base address of the active DLL entry
    logic        dli_flag;    // DLI bit latched from byte0 of the active entry
    logic        pending;     // one line_start seen while fetching
    logic [15:0] fetch_addr;
    logic        unused_rsvd;

    // Byte0 bit 4 carries no meaning for the fetcher.
    assign unused_rsvd = mem_data[DllRsvdBit];

    // Address of the entry byte wanted by the current fetch state.
    always_comb begin
        fetch_addr = ptr;
        case (state)
            StF0:    fetch_addr = dll_byte_addr(ptr, 2'd0);
            StF1:    fetch_addr = dll_byte_addr(ptr, 2'd1);
            StF2:    fetch_addr = dll_byte_addr(ptr, 2'd2);
            default: fetch_addr = ptr;
        endcase
    end

    // Fetch sequencer with registered outputs; frame_start overrides everything else.
    always_ff @(posedge sysclock) begin
        if (!reset_b) begin
            state    <= StIdle;
            ptr      <= 16'd0;
            dli_flag <= 1'b0;
            pending  <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= 16'd0;
            dl_ptr   <= 16'd0;
            offset   <= 4'd0;
            holey    <= 2'd0;
            dl_valid <= 1'b0;
            dli      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            dli <= 1'b0;
            if (frame_start) begin
                // Request always drops here; F0 raises it again a cycle later.
                pending  <= 1'b0;
                mem_req  <= 1'b0;
                dl_valid <= 1'b0;
                if (zp_written) begin
                    ptr   <= ZP;
                    state <= StF0;
                end else begin
                    state <= StIdle;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        // line_start ignored until a frame has started
                    end
                    StF0, StF1, StF2: begin
                        if (line_start) begin
                            if (pending) begin
                                overrun <= 1'b1;
                            end else begin
                                pending <= 1'b1;
                            end
                        end
                        if (!mem_req) begin
                            mem_req  <= 1'b1;
                            mem_addr <= fetch_addr;
                        end else if (mem_ack) begin
                            mem_req <= 1'b0;
                            if (state == StF0) begin
                                dli_flag <= mem_data[DllDliBit];
                                holey    <= {mem_data[DllH16Bit], mem_data[DllH8Bit]};
                                offset   <= mem_data[DllOffsetMsb:0];
                                state    <= StF1;
                            end else if (state == StF1) begin
                                dl_ptr[15:8] <= mem_data;
                                state        <= StF2;
                            end else begin
                                dl_ptr[7:0] <= mem_data;
                                dl_valid    <= 1'b1;
                                state       <= StReady;
                            end
                        end
                    end
                    StReady: begin
                        // A pending line is serviced in the first READY cycle; a fresh
                        // line_start arriving alongside it is one line too many.
                        if (pending || line_start) begin
                            pending <= 1'b0;
                            if (pending && line_start) begin
                                overrun <= 1'b1;
                            end
                            if (offset != 4'd0) begin
                                offset <= offset - 4'd1;
                            end else begin
                                dli      <= dli_flag;
                                ptr      <= ptr + 16'(DLL_ENTRY_BYTES);
                                dl_valid <= 1'b0;
                                state    <= StF0;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dll_fetcher.sv
// Self-checking bench for dll_fetcher: table of DLL entry fetches plus directed
// sequences for line stepping, overrun, frame/line collision and mid-fetch reset.
module tb_dll_fetcher;

    logic        sysclock;
    logic        reset_b;
    logic [15:0] zp;
    logic        zp_written;
    logic        frame_start;
    logic        line_start;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack  = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [15:0] dl_ptr;
    logic [3:0]  offset;
    logic [1:0]  holey;
    logic        dl_valid;
    logic        dli;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    // Memory model and responder controls.
    logic [7:0]  mem [0:65535];
    logic [15:0] addr_log [$];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        resp_en   = 1'b1;
    logic        late_ack  = 1'b0;

    typedef struct {
        logic [15:0] zp;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [15:0] exp_last;   // third fetch address
        logic [15:0] exp_ptr;
        logic [3:0]  exp_off;
        logic [1:0]  exp_holey;
    } vec_t;

    vec_t vecs [4];

    dll_fetcher dut (
        .sysclock    (sysclock),
        .reset_b     (reset_b),
        .ZP          (zp),
        .zp_written  (zp_written),
        .frame_start (frame_start),
        .line_start  (line_start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .dl_ptr      (dl_ptr),
        .offset      (offset),
        .holey       (holey),
        .dl_valid    (dl_valid),
        .dli         (dli),
        .overrun     (overrun)
    );

    initial sysclock = 1'b0;
    always #5 sysclock = ~sysclock;

    // Memory arbiter model: acks a request ack_delay falling edges after it appears.
    always @(negedge sysclock) begin
        if (!resp_en) begin
            mem_ack  = late_ack;
            mem_data = 8'hFF;
            wait_cnt = 0;
        end else if (mem_req && !mem_ack) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr];
                addr_log.push_back(mem_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            mem_data = 8'h00;
            wait_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge sysclock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_frame(input logic [15:0] zp_val, input logic zw);
        zp          = zp_val;
        zp_written  = zw;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (dl_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(dl_valid), 32'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [15:0] a);
        int n = 0;
        while (!(mem_req === 1'b1 && mem_addr === a) && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_req_addr"}, {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, a});
    endtask

    function automatic logic [15:0] logged(input int i);
        if (addr_log.size() > i) return addr_log[i];
        return 16'hDEAD;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},  32'(mem_req),  32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_dl_ptr"},   32'(dl_ptr),   32'd0);
        check({tag, "_offset"},   32'(offset),   32'd0);
        check({tag, "_holey"},    32'(holey),    32'd0);
        check({tag, "_dl_valid"}, 32'(dl_valid), 32'd0);
        check({tag, "_dli"},      32'(dli),      32'd0);
        check({tag, "_overrun"},  32'(overrun),  32'd0);
    endtask

    initial begin
        // 0x82: DLI, offset 2. 0x6F: H16+H8, offset F. 0x55: H16, bit4 ignored, offset 5.
        // 0x30: H8, bit4 ignored, offset 0. ZP 0xFFFE wraps its third read to 0x0000.
        vecs[0] = '{16'h1820, 8'h82, 8'h40, 8'h00, 16'h1822, 16'h4000, 4'h2, 2'd0};
        vecs[1] = '{16'hFFFE, 8'h6F, 8'h12, 8'h34, 16'h0000, 16'h1234, 4'hF, 2'd3};
        vecs[2] = '{16'h2000, 8'h55, 8'hA0, 8'h7F, 16'h2002, 16'hA07F, 4'h5, 2'd2};
        vecs[3] = '{16'h0100, 8'h30, 8'h00, 8'hFF, 16'h0102, 16'h00FF, 4'h0, 2'd1};
        foreach (vecs[i]) begin
            mem[vecs[i].zp]          = vecs[i].b0;
            mem[vecs[i].zp + 16'd1]  = vecs[i].b1;
            mem[vecs[i].zp + 16'd2]  = vecs[i].b2;
        end
        // Entry following 0x1820: no DLI, offset 0, DL at 0x1122.
        mem[16'h1823] = 8'h00;
        mem[16'h1824] = 8'h11;
        mem[16'h1825] = 8'h22;

        reset_b     = 1'b0;
        zp          = 16'h0000;
        zp_written  = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        tick();
        tick();
        tick();
        check_reset_outputs("reset");
        reset_b = 1'b1;
        tick();

        // line_start in IDLE and frame_start without ZP leave the fetcher idle.
        pulse_line();
        tick();
        check("idle_line_req", 32'(mem_req), 32'd0);
        check("idle_line_dli", 32'(dli), 32'd0);
        check("idle_line_ovr", 32'(overrun), 32'd0);
        pulse_frame(16'h1820, 1'b0);
        tick();
        tick();
        check("nozp_req", 32'(mem_req), 32'd0);
        check("nozp_reads", 32'(addr_log.size()), 32'd0);

        // Table of entry fetches.
        for (int i = 0; i < 4; i++) begin
            addr_log.delete();
            pulse_frame(vecs[i].zp, 1'b1);
            wait_ready($sformatf("vec%0d", i));
            check($sformatf("vec%0d_nreads", i), 32'(addr_log.size()), 32'd3);
            check($sformatf("vec%0d_addr0", i), 32'(logged(0)), 32'(vecs[i].zp));
            check($sformatf("vec%0d_addr1", i), 32'(logged(1)), 32'(vecs[i].zp + 16'd1));
            check($sformatf("vec%0d_addr2", i), 32'(logged(2)), 32'(vecs[i].exp_last));
            check($sformatf("vec%0d_dl_ptr", i), 32'(dl_ptr), 32'(vecs[i].exp_ptr));
            check($sformatf("vec%0d_offset", i), 32'(offset), 32'(vecs[i].exp_off));
            check($sformatf("vec%0d_holey", i), 32'(holey), 32'(vecs[i].exp_holey));
            check($sformatf("vec%0d_req", i), 32'(mem_req), 32'd0);
        end

        // Line stepping through a zone and on to the next entry.
        addr_log.delete();
        pulse_frame(16'h1820, 1'b1);
        wait_ready("step");
        pulse_line();
        check("step1_offset", 32'(offset), 32'd1);
        check("step1_dli", 32'(dli), 32'd0);
        pulse_line();
        check("step2_offset", 32'(offset), 32'd0);
        check("step2_valid", 32'(dl_valid), 32'd1);
        addr_log.delete();
        pulse_line();
        check("step3_dli", 32'(dli), 32'd1);
        check("step3_valid", 32'(dl_valid), 32'd0);
        tick();
        check("step3_dli_pulse", 32'(dli), 32'd0);
        wait_ready("step_next");
        check("step_next_addr0", 32'(logged(0)), 32'h1823);
        check("step_next_dl_ptr", 32'(dl_ptr), 32'h1122);

        // Two line_starts during one slow fetch: overrun plus exactly one serviced line.
        ack_delay = 10;
        pulse_frame(16'h1820, 1'b1);
        pulse_line();
        tick();
        tick();
        pulse_line();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_fetching", 32'(dl_valid), 32'd0);
        wait_ready("ovr");
        check("ovr_first_ready_off", 32'(offset), 32'd2);
        tick();
        check("ovr_serviced_off", 32'(offset), 32'd1);
        tick();
        check("ovr_once_off", 32'(offset), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // frame_start and line_start together mid-F1: restart, no pending line.
        ack_delay = 3;
        pulse_frame(16'h1820, 1'b1);
        wait_addr("coll", 16'h1821);
        zp          = 16'h2000;
        frame_start = 1'b1;
        line_start  = 1'b1;
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
        check("coll_req_drop", 32'(mem_req), 32'd0);
        check("coll_dli", 32'(dli), 32'd0);
        addr_log.delete();
        ack_delay = 0;
        wait_ready("coll");
        check("coll_addr0", 32'(logged(0)), 32'h2000);
        check("coll_dl_ptr", 32'(dl_ptr), 32'hA07F);
        check("coll_offset", 32'(offset), 32'd5);
        tick();
        check("coll_no_decrement", 32'(offset), 32'd5);
        check("coll_dli_after", 32'(dli), 32'd0);

        // Reset during F1 with a request outstanding; a late ack is ignored.
        ack_delay = 10;
        pulse_frame(16'h1820, 1'b1);
        wait_addr("rst", 16'h1821);
        resp_en = 1'b0;
        reset_b = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        reset_b  = 1'b1;
        late_ack = 1'b1;
        tick();
        late_ack = 1'b0;
        check("rst_late_ack_req", 32'(mem_req), 32'd0);
        check("rst_late_ack_ptr", 32'(dl_ptr), 32'd0);
        tick();
        check("rst_late_ack_idle", 32'(mem_req), 32'd0);
        check("rst_late_ack_valid", 32'(dl_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
